// File: rtl/cart_cpu_bus_master_if.sv
// Request/response channel and cartridge-edge signals of the CPU-side bus master.
// The master modport is the bus initiator; the slave modport is the requester/cart side.
interface cart_cpu_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        m2;
    logic        romsel;
    logic        cpu_rw;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_data_oe;
    logic [7:0]  cpu_data_in;
    logic [15:0] bus_cycle_count;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, cpu_data_in,
        output req_ready, rsp_valid, rsp_rdata, m2, romsel, cpu_rw, cpu_addr,
               cpu_data_out, cpu_data_oe, bus_cycle_count
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, cpu_data_in,
        input  req_ready, rsp_valid, rsp_rdata, m2, romsel, cpu_rw, cpu_addr,
               cpu_data_out, cpu_data_oe, bus_cycle_count
    );
endinterface

// File: rtl/cart_cpu_bus_master.sv
// NES/Famicom CPU-side bus initiator: turns request/response transfers into free-running
// M2 bus cycles toward the cartridge, filling gaps with idle reads so m2 never stops.
//
// state    | meaning
// ST_RESET | held in reset; the first clk after release starts an idle LOW phase
// ST_LOW   | m2=0 phase; a new bus cycle's address/rw/data are presented from its first clk
// ST_HIGH  | m2=1 phase; romsel/oe active, last clk is the request-acceptance slot
module cart_cpu_bus_master #(
    parameter int unsigned M2_LOW_CYCLES  = 4,
    parameter int unsigned M2_HIGH_CYCLES = 4,
    parameter logic [15:0] IDLE_ADDR      = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    cart_cpu_bus_master_if.master bus
);
    localparam int unsigned MAX_PH = (M2_LOW_CYCLES > M2_HIGH_CYCLES) ? M2_LOW_CYCLES
                                                                      : M2_HIGH_CYCLES;
    localparam int unsigned PH_W = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;
    localparam logic [PH_W-1:0] LOW_LOAD  = PH_W'(M2_LOW_CYCLES - 1);
    localparam logic [PH_W-1:0] HIGH_LOAD = PH_W'(M2_HIGH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RESET = 2'b00,
        ST_LOW   = 2'b01,
        ST_HIGH  = 2'b10
    } state_t;

    state_t         state, state_nx;
    logic [PH_W-1:0] phase_cnt, phase_nx;
    logic           cycle_start, cycle_end;

    logic           cyc_req_q, cyc_req_nx;
    logic           cyc_write_q, cyc_write_nx;
    logic           cyc_a15_q, cyc_a15_nx;
    logic           accept;

    logic           m2_q, m2_nx;
    logic           romsel_q, romsel_nx;
    logic           cpu_rw_q, cpu_rw_nx;
    logic [14:0]    cpu_addr_q, cpu_addr_nx;
    logic [7:0]     data_out_q, data_out_nx;
    logic           data_oe_q, data_oe_nx;
    logic           req_ready_q, req_ready_nx;
    logic           rsp_valid_q, rsp_valid_nx;
    logic [7:0]     rsp_rdata_q, rsp_rdata_nx;
    logic [15:0]    cycle_cnt_q, cycle_cnt_nx;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_RESET;
            phase_cnt <= '0;
        end else begin
            state     <= state_nx;
            phase_cnt <= phase_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        phase_nx    = phase_cnt;
        cycle_start = 1'b0;
        cycle_end   = 1'b0;
        case (state)
            ST_LOW: begin
                if (phase_cnt == '0) begin
                    state_nx = ST_HIGH;
                    phase_nx = HIGH_LOAD;
                end else begin
                    phase_nx = phase_cnt - PH_W'(1);
                end
            end
            ST_HIGH: begin
                if (phase_cnt == '0) begin
                    state_nx    = ST_LOW;
                    phase_nx    = LOW_LOAD;
                    cycle_start = 1'b1;
                    cycle_end   = 1'b1;
                end else begin
                    phase_nx = phase_cnt - PH_W'(1);
                end
            end
            default: begin
                state_nx    = ST_LOW;
                phase_nx    = LOW_LOAD;
                cycle_start = 1'b1;
            end
        endcase
    end

    // req_ready is high only on the last HIGH clk, so this is the single acceptance point
    // and coincides with the edge that launches the next bus cycle.
    always_comb begin
        accept       = req_ready_q & bus.req_valid;

        cyc_req_nx   = cyc_req_q;
        cyc_write_nx = cyc_write_q;
        cyc_a15_nx   = cyc_a15_q;
        cpu_addr_nx  = cpu_addr_q;
        cpu_rw_nx    = cpu_rw_q;
        data_out_nx  = data_out_q;
        if (cycle_start) begin
            cyc_req_nx   = accept;
            cyc_write_nx = accept & bus.req_write;
            cyc_a15_nx   = accept ? bus.req_addr[15] : IDLE_ADDR[15];
            cpu_addr_nx  = accept ? bus.req_addr[14:0] : IDLE_ADDR[14:0];
            cpu_rw_nx    = ~(accept & bus.req_write);
            if (accept && bus.req_write) begin
                data_out_nx = bus.req_wdata;
            end
        end

        m2_nx        = (state_nx == ST_HIGH);
        romsel_nx    = ~(cyc_a15_nx & m2_nx);
        data_oe_nx   = m2_nx & cyc_write_nx;
        req_ready_nx = (state_nx == ST_HIGH) && (phase_nx == '0);

        rsp_valid_nx = cycle_end & cyc_req_q;
        rsp_rdata_nx = rsp_rdata_q;
        if (cycle_end && cyc_req_q && !cyc_write_q) begin
            rsp_rdata_nx = bus.cpu_data_in;
        end
        cycle_cnt_nx = cycle_end ? (cycle_cnt_q + 16'd1) : cycle_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cyc_req_q   <= 1'b0;
            cyc_write_q <= 1'b0;
            cyc_a15_q   <= IDLE_ADDR[15];
            m2_q        <= 1'b0;
            romsel_q    <= 1'b1;
            cpu_rw_q    <= 1'b1;
            cpu_addr_q  <= IDLE_ADDR[14:0];
            data_out_q  <= 8'h00;
            data_oe_q   <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            cycle_cnt_q <= 16'h0000;
        end else begin
            cyc_req_q   <= cyc_req_nx;
            cyc_write_q <= cyc_write_nx;
            cyc_a15_q   <= cyc_a15_nx;
            m2_q        <= m2_nx;
            romsel_q    <= romsel_nx;
            cpu_rw_q    <= cpu_rw_nx;
            cpu_addr_q  <= cpu_addr_nx;
            data_out_q  <= data_out_nx;
            data_oe_q   <= data_oe_nx;
            req_ready_q <= req_ready_nx;
            rsp_valid_q <= rsp_valid_nx;
            rsp_rdata_q <= rsp_rdata_nx;
            cycle_cnt_q <= cycle_cnt_nx;
        end
    end

    assign bus.m2              = m2_q;
    assign bus.romsel          = romsel_q;
    assign bus.cpu_rw          = cpu_rw_q;
    assign bus.cpu_addr        = cpu_addr_q;
    assign bus.cpu_data_out    = data_out_q;
    assign bus.cpu_data_oe     = data_oe_q;
    assign bus.req_ready       = req_ready_q;
    assign bus.rsp_valid       = rsp_valid_q;
    assign bus.rsp_rdata       = rsp_rdata_q;
    assign bus.bus_cycle_count = cycle_cnt_q;
endmodule

// File: tb/tb_cart_cpu_bus_master.sv
// Bench for cart_cpu_bus_master: default-timing instance driven through a response
// scoreboard, plus a 2/3-clk instance used for m2 period and cycle-counter wrap.
module tb_cart_cpu_bus_master;
    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    cart_cpu_bus_master_if bus ();
    cart_cpu_bus_master_if bus_f ();

    cart_cpu_bus_master u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    cart_cpu_bus_master #(
        .M2_LOW_CYCLES  (2),
        .M2_HIGH_CYCLES (3),
        .IDLE_ADDR      (16'h0000)
    ) u_fast (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_f)
    );

    // cart model: read data is a fixed function of the presented address
    function automatic logic [7:0] cart_byte(input logic [14:0] a);
        return a[7:0] + 8'hA0;
    endfunction

    assign bus.cpu_data_in   = cart_byte(bus.cpu_addr);
    assign bus_f.cpu_data_in = 8'h00;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0]  data;
        int unsigned t;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned rsp_times[$];
    int unsigned cyc = 0;
    logic [7:0]  last_rd = 8'h00;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!reset_n) begin
            sb_q.delete();
            last_rd = 8'h00;
        end else begin
            if (bus.req_valid && bus.req_ready) begin
                if (bus.req_write) begin
                    e.data = last_rd;
                end else begin
                    e.data  = cart_byte(bus.req_addr[14:0]);
                    last_rd = e.data;
                end
                e.t = cyc;
                sb_q.push_back(e);
            end
            if (bus.rsp_valid) begin
                rsp_times.push_back(cyc);
                if (sb_q.size() == 0) begin
                    check_eq("rsp_unexpected", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("rsp_rdata", bus.rsp_rdata, e.data);
                    check_eq("rsp_latency", cyc - e.t, 9);
                end
            end
        end
    end

    task automatic send(input logic wr, input logic [15:0] a, input logic [7:0] d, input bit hold);
        bit got = 0;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                got = 1;
                break;
            end
        end
        check_eq("accept_timeout", 32'(got), 1);
        @(posedge clk);
        #1;
        if (!hold) bus.req_valid = 1'b0;
    endtask

    // samples the 8 clks of the cycle launched right after acceptance
    task automatic watch_cycle(input logic wr, input logic [15:0] a, input logic [7:0] d);
        int e_m2 = 0, e_rs = 0, e_rw = 0, e_ad = 0, e_oe = 0, e_do = 0;
        logic m2e;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            m2e = (k > 4);
            if (bus.m2 !== m2e) e_m2++;
            if (bus.romsel !== ~(a[15] & m2e)) e_rs++;
            if (bus.cpu_rw !== ~wr) e_rw++;
            if (bus.cpu_addr !== a[14:0]) e_ad++;
            if (bus.cpu_data_oe !== (wr & m2e)) e_oe++;
            if (wr && bus.cpu_data_out !== d) e_do++;
        end
        check_eq("cyc_m2", e_m2, 0);
        check_eq("cyc_romsel", e_rs, 0);
        check_eq("cyc_rw", e_rw, 0);
        check_eq("cyc_addr", e_ad, 0);
        check_eq("cyc_oe", e_oe, 0);
        check_eq("cyc_wdata", e_do, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e_m2, e_rs, e_rw, e_ad, e_rdy, e_fm2;
        int unsigned n_rsp, t_fall;
        bit seen;

        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_addr    = 16'h0000;
        bus.req_wdata   = 8'h00;
        bus_f.req_valid = 1'b0;
        bus_f.req_write = 1'b0;
        bus_f.req_addr  = 16'h0000;
        bus_f.req_wdata = 8'h00;

        repeat (3) @(negedge clk);
        check_eq("rst_m2", bus.m2, 0);
        check_eq("rst_romsel", bus.romsel, 1);
        check_eq("rst_rw", bus.cpu_rw, 1);
        check_eq("rst_addr", bus.cpu_addr, 0);
        check_eq("rst_oe", bus.cpu_data_oe, 0);
        check_eq("rst_dout", bus.cpu_data_out, 0);
        check_eq("rst_ready", bus.req_ready, 0);
        check_eq("rst_rsp_valid", bus.rsp_valid, 0);
        check_eq("rst_rdata", bus.rsp_rdata, 0);
        check_eq("rst_count", bus.bus_cycle_count, 0);
        reset_n = 1'b1;

        // idle run: 10 full cycles, fast instance checked against its 2/3 pattern
        e_m2 = 0; e_rs = 0; e_rw = 0; e_ad = 0; e_rdy = 0; e_fm2 = 0;
        for (int p = 1; p <= 80; p++) begin
            @(negedge clk);
            if (bus.m2 !== (((p - 1) % 8) >= 4)) e_m2++;
            if (bus.romsel !== 1'b1) e_rs++;
            if (bus.cpu_rw !== 1'b1) e_rw++;
            if (bus.cpu_addr !== 15'h0000) e_ad++;
            if (bus.req_ready !== ((p % 8) == 0)) e_rdy++;
            if (bus_f.m2 !== (((p - 1) % 5) >= 2)) e_fm2++;
        end
        check_eq("idle_m2_pattern", e_m2, 0);
        check_eq("idle_romsel", e_rs, 0);
        check_eq("idle_rw", e_rw, 0);
        check_eq("idle_addr", e_ad, 0);
        check_eq("idle_ready_pattern", e_rdy, 0);
        check_eq("fast_m2_pattern", e_fm2, 0);
        @(negedge clk);
        check_eq("idle_count", bus.bus_cycle_count, 10);
        check_eq("idle_no_rsp", rsp_times.size(), 0);

        // counter wrap on the fast instance, preloaded while m2 is high
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus_f.m2) begin seen = 1; break; end
            @(negedge clk);
        end
        check_eq("fast_find_high", 32'(seen), 1);
        force u_fast.cycle_cnt_q = 16'hFFFE;
        #1;
        release u_fast.cycle_cnt_q;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus_f.m2) begin seen = 1; break; end
        end
        check_eq("fast_fall1", 32'(seen), 1);
        check_eq("fast_count_ffff", bus_f.bus_cycle_count, 16'hFFFF);
        t_fall = cyc;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_f.m2) begin seen = 1; break; end
        end
        for (int i = 0; i < 10 && seen; i++) begin
            @(negedge clk);
            if (!bus_f.m2) break;
        end
        check_eq("fast_count_0000", bus_f.bus_cycle_count, 16'h0000);
        check_eq("fast_period", cyc - t_fall, 5);

        // single read from ROM space
        send(1'b0, 16'h8005, 8'h00, 0);
        watch_cycle(1'b0, 16'h8005, 8'h00);
        @(negedge clk);
        check_eq("read_rsp_valid", bus.rsp_valid, 1);
        check_eq("read_rdata", bus.rsp_rdata, 8'hA5);
        @(negedge clk);
        check_eq("read_rsp_pulse", bus.rsp_valid, 0);

        // single write outside ROM space
        repeat (3) @(negedge clk);
        send(1'b1, 16'h6000, 8'h3C, 0);
        watch_cycle(1'b1, 16'h6000, 8'h3C);
        @(negedge clk);
        check_eq("write_rsp_valid", bus.rsp_valid, 1);
        check_eq("write_rdata_hold", bus.rsp_rdata, 8'hA5);

        // back-to-back reads with req_valid held
        repeat (5) @(negedge clk);
        n_rsp = rsp_times.size();
        send(1'b0, 16'h8000, 8'h00, 1);
        send(1'b0, 16'hC001, 8'h00, 1);
        send(1'b0, 16'hFFFF, 8'h00, 0);
        repeat (20) @(negedge clk);
        check_eq("b2b_rsp_count", rsp_times.size() - n_rsp, 3);
        if (rsp_times.size() >= n_rsp + 3) begin
            check_eq("b2b_gap1", rsp_times[n_rsp + 1] - rsp_times[n_rsp], 8);
            check_eq("b2b_gap2", rsp_times[n_rsp + 2] - rsp_times[n_rsp + 1], 8);
        end
        check_eq("b2b_last_rdata", bus.rsp_rdata, 8'h9F);

        // reset during the 2nd HIGH clk of a ROM-space write
        n_rsp = rsp_times.size();
        send(1'b1, 16'h8123, 8'h77, 0);
        repeat (6) @(negedge clk);
        check_eq("abort_pre_m2", bus.m2, 1);
        check_eq("abort_pre_oe", bus.cpu_data_oe, 1);
        check_eq("abort_pre_romsel", bus.romsel, 0);
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("abort_m2", bus.m2, 0);
        check_eq("abort_oe", bus.cpu_data_oe, 0);
        check_eq("abort_rw", bus.cpu_rw, 1);
        check_eq("abort_romsel", bus.romsel, 1);
        check_eq("abort_rsp_valid", bus.rsp_valid, 0);
        check_eq("abort_count", bus.bus_cycle_count, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (9) @(negedge clk);
        check_eq("abort_count_restart", bus.bus_cycle_count, 1);
        repeat (12) @(negedge clk);
        check_eq("abort_no_rsp", rsp_times.size() - n_rsp, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
